// File: rtl/loader_pkg.sv
// Shared types and constants for the EPCS program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [7:0] EPCS_READ_CMD = 8'h03;
    localparam int         CMD_BITS      = 8;
    localparam int         ADDR_BITS     = 24;
    localparam int         WORD_BITS     = 16;

endpackage

// File: rtl/spi_bit_engine.sv
// Serial bit timing for the EPCS link: DCLK divider, clock phase and a
// 16-bit shift register shared by the transmit and receive directions.
module spi_bit_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic        run,
    input  logic        sdi,
    output logic        dclk,
    output logic        sdo,
    output logic        bit_done,
    output logic [15:0] shreg_q
);

    localparam int                DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_TC = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             ph;
    logic             samp;
    logic [15:0]      shreg;
    logic             tc;

    assign tc       = (div_cnt == '0);
    // Last cycle of the high phase; the FSM gates this with its own state.
    assign bit_done = ph & tc;
    assign dclk     = ph;
    assign sdo      = shreg[15];
    assign shreg_q  = shreg;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            div_cnt <= DIV_TC;
            ph      <= 1'b0;
            samp    <= 1'b0;
            shreg   <= '0;
        end else if (load) begin
            div_cnt <= DIV_TC;
            ph      <= 1'b0;
            shreg   <= load_data;
        end else if (run) begin
            if (tc) begin
                div_cnt <= DIV_TC;
                ph      <= ~ph;
                // Capture on the rising edge, shift on the falling edge so the
                // outgoing bit only moves at the start of the low phase.
                if (!ph) begin
                    samp <= sdi;
                end else begin
                    shreg <= {shreg[14:0], samp};
                end
            end else begin
                div_cnt <= div_cnt - 1'b1;
            end
        end else begin
            div_cnt <= DIV_TC;
            ph      <= 1'b0;
        end
    end

endmodule

// File: rtl/epcs_program_loader.sv
// Copies N_WORDS 16-bit words from EPCS flash into program memory using one
// continuous READ (0x03) transaction; auto-loads after reset and on start.
//
// state  | meaning
// IDLE   | waiting for auto-load after reset or a start request
// CMD    | one setup cycle, then 8 opcode bits shifted out
// ADDR   | 24 address bits shifted out
// DATA   | 16 data bits shifted in for the current word
// WRITE  | one-cycle program-memory write of the assembled word
// FINISH | image valid, chip deselected, waiting for start
module epcs_program_loader
    import loader_pkg::*;
#(
    parameter int          CLK_DIV   = 2,
    parameter int          N_WORDS   = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              start,
    output logic              EPCS_DCLK,
    output logic              EPCS_NCSO,
    output logic              EPCS_ASDO,
    input  logic              EPCS_DATA0,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(N_WORDS - 1);
    localparam logic [4:0]        CMD_LAST   = 5'(CMD_BITS - 1);
    localparam logic [4:0]        ADDR_LAST  = 5'(ADDR_BITS - 1);
    localparam logic [4:0]        WORD_LAST  = 5'(WORD_BITS - 1);
    localparam logic [4:0]        ADDR_SPLIT = 5'(ADDR_BITS - WORD_BITS);

    state_t            state, nstate;
    logic              auto_ld;
    logic              cmd_first;
    logic              go;
    logic [4:0]        bit_cnt;
    logic [ADDR_W-1:0] word_cnt;

    logic              load;
    logic [15:0]       load_data;
    logic              run;
    logic              eng_dclk;
    logic              eng_sdo;
    logic              bit_done;
    logic [15:0]       shreg_q;

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .load      (load),
        .load_data (load_data),
        .run       (run),
        .sdi       (EPCS_DATA0),
        .dclk      (eng_dclk),
        .sdo       (eng_sdo),
        .bit_done  (bit_done),
        .shreg_q   (shreg_q)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= IDLE;
            auto_ld   <= 1'b1;
            cmd_first <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            state     <= nstate;
            auto_ld   <= 1'b0;
            cmd_first <= go;
            if (go) begin
                bit_cnt  <= CMD_LAST;
                word_cnt <= '0;
            end else if (bit_done && state != IDLE && state != FINISH) begin
                if (bit_cnt == '0) begin
                    bit_cnt <= (state == CMD) ? ADDR_LAST : WORD_LAST;
                end else begin
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end
            if (state == WRITE && word_cnt != LAST_WORD) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nstate    = state;
        go        = 1'b0;
        load      = 1'b0;
        load_data = 16'h0000;
        run       = 1'b0;
        case (state)
            IDLE: begin
                if (auto_ld || start) begin
                    go     = 1'b1;
                    nstate = CMD;
                end
            end
            CMD: begin
                if (cmd_first) begin
                    load      = 1'b1;
                    load_data = {EPCS_READ_CMD, 8'h00};
                end else begin
                    run = 1'b1;
                    if (bit_done && bit_cnt == '0) begin
                        nstate    = ADDR;
                        load      = 1'b1;
                        load_data = BASE_ADDR[23:8];
                    end
                end
            end
            ADDR: begin
                run = 1'b1;
                if (bit_done) begin
                    // The register only holds 16 bits; refill with the low byte.
                    if (bit_cnt == ADDR_SPLIT) begin
                        load      = 1'b1;
                        load_data = {BASE_ADDR[7:0], 8'h00};
                    end else if (bit_cnt == '0) begin
                        nstate = DATA;
                    end
                end
            end
            DATA: begin
                run = 1'b1;
                if (bit_done && bit_cnt == '0) begin
                    nstate = WRITE;
                end
            end
            WRITE: begin
                nstate = (word_cnt == LAST_WORD) ? FINISH : DATA;
            end
            FINISH: begin
                if (start) begin
                    go     = 1'b1;
                    nstate = CMD;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // Chip select stays low across WRITE gaps so the read never restarts.
    assign EPCS_NCSO = !(state == CMD || state == ADDR || state == DATA || state == WRITE);
    assign EPCS_DCLK = eng_dclk;
    assign EPCS_ASDO = eng_sdo & ((state == CMD && !cmd_first) || state == ADDR);
    assign busy      = (state == CMD || state == ADDR || state == DATA || state == WRITE);
    assign done      = (state == FINISH);
    assign mem_we    = (state == WRITE);
    assign mem_addr  = word_cnt;
    assign mem_wdata = shreg_q;

endmodule

// File: tb/tb_epcs_program_loader.sv
// Scoreboard bench: a behavioural EPCS flash model serves a byte image and the
// expected program-memory writes are derived from that image per load.
module tb_epcs_program_loader;

    localparam int          CLK_DIV  = 2;
    localparam int          N_WORDS  = 16;
    localparam int          ADDR_W   = 4;
    localparam logic [23:0] BASE     = 24'h010000;
    localparam int          LOAD_CYC = 32*2*CLK_DIV + N_WORDS*(32*CLK_DIV+1) + 1;

    logic              CLOCK_50 = 1'b0;
    logic              RESET;
    logic              start;
    logic              EPCS_DCLK, EPCS_NCSO, EPCS_ASDO;
    logic              EPCS_DATA0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy, done;

    epcs_program_loader #(
        .CLK_DIV   (CLK_DIV),
        .N_WORDS   (N_WORDS),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .start      (start),
        .EPCS_DCLK  (EPCS_DCLK),
        .EPCS_NCSO  (EPCS_NCSO),
        .EPCS_ASDO  (EPCS_ASDO),
        .EPCS_DATA0 (EPCS_DATA0),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash image starting at BASE: byte 2i is the high byte of word i.
    logic [7:0] img [0:2*N_WORDS-1];

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    // ---------------- flash model ----------------
    int          rise_cnt = 0;
    logic [31:0] hdr = '0;

    always @(negedge EPCS_NCSO) rise_cnt = 0;

    always @(posedge EPCS_DCLK) begin
        if (!EPCS_NCSO) begin
            if (rise_cnt < 32) hdr = {hdr[30:0], EPCS_ASDO};
            rise_cnt++;
            if (rise_cnt == 32) check("cmd_addr_stream", hdr, {8'h03, BASE});
        end
    end

    always @(negedge EPCS_DCLK) begin : fl_out
        int k;
        int off;
        if (!EPCS_NCSO && rise_cnt >= 32) begin
            k   = rise_cnt - 32;
            off = int'(hdr[23:0]) - int'(BASE) + k / 8;
            if (off >= 0 && off < 2*N_WORDS) EPCS_DATA0 = img[off][7 - (k % 8)];
            else                             EPCS_DATA0 = 1'b0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int   cyc = 0, t_start = 0, wr_cnt = 0, ncso_falls = 0, done_seen = 0;
    logic prev_busy = 1'b0, prev_done = 1'b0, prev_ncso = 1'b1;
    logic prev_dclk = 1'b0, prev_asdo = 1'b0;

    always @(negedge CLOCK_50) begin
        wr_t w;
        cyc++;
        if (busy && !prev_busy) begin
            t_start    = cyc;
            wr_cnt     = 0;
            ncso_falls = 0;
            exp_q.delete();
            for (int i = 0; i < N_WORDS; i++) begin
                w.addr = i;
                w.data = {img[2*i], img[2*i+1]};
                exp_q.push_back(w);
            end
        end
        if (!EPCS_NCSO && prev_ncso) ncso_falls++;
        if (mem_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h with nothing expected", mem_addr, mem_wdata);
            end else begin
                w = exp_q.pop_front();
                check("write_addr", mem_addr, w.addr);
                check("write_data", mem_wdata, w.data);
            end
        end
        if (done && !prev_done) begin
            done_seen++;
            check("load_cycles", cyc - t_start, LOAD_CYC);
            check("ncso_windows", ncso_falls, 1);
            check("write_count", wr_cnt, N_WORDS);
            check("busy_low_at_done", busy, 1'b0);
            check("writes_outstanding", exp_q.size(), 0);
        end
        if (EPCS_DCLK && prev_dclk) check("asdo_stable_dclk_high", EPCS_ASDO, prev_asdo);
        if (EPCS_NCSO) begin
            check("dclk_low_deselected", EPCS_DCLK, 1'b0);
            check("asdo_low_deselected", EPCS_ASDO, 1'b0);
        end
        prev_busy = busy;
        prev_done = done;
        prev_ncso = EPCS_NCSO;
        prev_dclk = EPCS_DCLK;
        prev_asdo = EPCS_ASDO;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            tick();
            n++;
        end
        check("done_within_budget", done, 1'b1);
    endtask

    task automatic randomize_img();
        for (int i = 0; i < 2*N_WORDS; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int rises;
        logic pd;

        RESET      = 1'b1;
        start      = 1'b0;
        EPCS_DATA0 = 1'b0;
        randomize_img();
        img[0] = 8'h01; img[1] = 8'h10;
        img[2] = 8'h00; img[3] = 8'h10;
        img[4] = 8'hd0; img[5] = 8'h01;

        repeat (3) tick();
        check("rst_ncso", EPCS_NCSO, 1'b1);
        check("rst_dclk", EPCS_DCLK, 1'b0);
        check("rst_asdo", EPCS_ASDO, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        // start during reset must not launch a load
        start = 1'b1;
        tick();
        check("start_with_reset_ignored", busy, 1'b0);
        start = 1'b0;

        RESET = 1'b0;
        tick();
        check("autoload_cmd_entry", busy, 1'b1);
        check("autoload_ncso_low", EPCS_NCSO, 1'b0);
        wait_done(LOAD_CYC + 50);

        for (int r = 0; r < 3; r++) begin
            randomize_img();
            repeat ($urandom_range(1, 20)) tick();
            pulse_start();
            check("reload_done_drops", done, 1'b0);
            check("reload_busy", busy, 1'b1);
            repeat ($urandom_range(5, 1000)) tick();
            pulse_start();
            wait_done(LOAD_CYC + 50);
        end

        // abort on the fifth data bit of word 2
        randomize_img();
        tick();
        pulse_start();
        n = 0;
        while (mem_addr != 2 && n < LOAD_CYC) begin
            tick();
            n++;
        end
        check("reached_word2", mem_addr, 2);
        rises = 0;
        pd    = EPCS_DCLK;
        n     = 0;
        while (rises < 5 && n < 500) begin
            tick();
            if (EPCS_DCLK && !pd) rises++;
            pd = EPCS_DCLK;
            n++;
        end
        check("fifth_bit_reached", rises, 5);
        RESET = 1'b1;
        tick();
        check("abort_ncso", EPCS_NCSO, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_dclk", EPCS_DCLK, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_write", mem_we, 1'b0);
            tick();
        end
        RESET = 1'b0;
        tick();
        check("abort_autoload", busy, 1'b1);
        wait_done(LOAD_CYC + 50);
        repeat (5) tick();

        check("loads_completed", done_seen, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
